// File: rtl/gf180mcu_fd_sc_mcu9t5v0__tbus_arb.sv
// Round-robin arbiter for a shared tristate net driven by NREQ bufz cells.
// Break-before-make: EN/GNT drop together, then DEAD_CYC+IDLE all-low cycles before a new owner.
module gf180mcu_fd_sc_mcu9t5v0__tbus_arb #(
  parameter int NREQ     = 4,
  parameter int DEAD_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                     CLK,
  input  logic                     RN,
  input  logic [NREQ-1:0]          REQ,
  output logic [NREQ-1:0]          GNT,
  output logic [NREQ-1:0]          EN,
  output logic [$clog2(NREQ)-1:0]  OWNER,
  output logic                     IDLE,
  inout  wire                      VDD,
  inout  wire                      VSS
);

  localparam int OW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 2);
  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRIVE, S_DEAD} state_t;

  state_t          state, state_n;
  logic [OW-1:0]   rr_ptr, rr_n, win, cand, owner_n;
  logic [HW-1:0]   hold_cnt, hold_n, hold_inc;
  logic [DW-1:0]   dead_cnt, dead_n;
  logic [NREQ-1:0] gnt_n, en_n, own_oh;
  logic            idle_n, found, preempt;

  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  // rr_ptr doubles as the current owner index while in GRANT/DRIVE
  assign own_oh   = NREQ'(1) << rr_ptr;
  assign hold_inc = (&hold_cnt) ? hold_cnt : hold_cnt + HW'(1);
  assign preempt  = (MAX_HOLD != 0) && (int'(hold_cnt) >= MAX_HOLD) && (|(REQ & ~own_oh));

  always_comb begin
    win   = rr_ptr;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = OW'((32'(rr_ptr) + k) % NREQ);
      if (!found && REQ[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    hold_n  = hold_cnt;
    dead_n  = dead_cnt;
    gnt_n   = '0;
    en_n    = '0;
    owner_n = '0;
    idle_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (|REQ) begin
          state_n = S_GRANT;
          rr_n    = win;
          hold_n  = HW'(1);
          gnt_n   = NREQ'(1) << win;
          owner_n = win;
        end else begin
          idle_n = 1'b1;
        end
      end
      S_GRANT: begin
        if (REQ[rr_ptr]) begin
          state_n = S_DRIVE;
          gnt_n   = own_oh;
          en_n    = own_oh;
          owner_n = rr_ptr;
          hold_n  = hold_inc;
        end else begin
          state_n = S_IDLE;
          idle_n  = 1'b1;
          hold_n  = '0;
        end
      end
      S_DRIVE: begin
        if (!REQ[rr_ptr] || preempt) begin
          hold_n = '0;
          if (DEAD_CYC == 0) begin
            state_n = S_IDLE;
            idle_n  = 1'b1;
          end else begin
            state_n = S_DEAD;
            dead_n  = '0;
          end
        end else begin
          gnt_n   = own_oh;
          en_n    = own_oh;
          owner_n = rr_ptr;
          hold_n  = hold_inc;
        end
      end
      S_DEAD: begin
        if (int'(dead_cnt) + 1 >= DEAD_CYC) begin
          state_n = S_IDLE;
          idle_n  = 1'b1;
        end else begin
          dead_n = dead_cnt + DW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        idle_n  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state    <= S_IDLE;
      rr_ptr   <= OW'(NREQ - 1);
      hold_cnt <= '0;
      dead_cnt <= '0;
      GNT      <= '0;
      EN       <= '0;
      OWNER    <= '0;
      IDLE     <= 1'b1;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_n;
      hold_cnt <= hold_n;
      dead_cnt <= dead_n;
      GNT      <= gnt_n;
      EN       <= en_n;
      OWNER    <= owner_n;
      IDLE     <= idle_n;
    end
  end

endmodule
